// File: rtl/usb_cdc_stream_tx.sv
// usb_cdc_stream_tx: buffers a user byte stream and frames it into packets for the CDC bulk IN endpoint.
// Defining USB_CDC_TX_ZLP_EN adds zero-length-packet termination after a full-size packet.
module usb_cdc_stream_tx #(
    parameter int DEPTH    = 256,
    parameter int MAX_PKT  = 64,
    parameter int TIMEOUT  = 1024,
    parameter int IN_BYTES = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      online_i,
    input  logic [8*IN_BYTES-1:0]     s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic                      ep_ready_i,
    output logic                      ep_dval_o,
    output logic [7:0]                ep_data_o,
    output logic                      ep_pktend_o,
    output logic                      ep_zlp_o,
    output logic [$clog2(DEPTH):0]    fill_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(MAX_PKT + 1);

`ifdef USB_CDC_TX_ZLP_EN
    typedef enum logic [1:0] {IDLE, SEND, HOLD, ZLP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d, freeSpace;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   pktLen_q, pktLen_d, pktCnt_q, pktCnt_d;
    logic            dval_q, dval_d, pktend_q, pktend_d, zlp_q, zlp_d;
    logic [7:0]      data_q, data_d;
    logic            push, pop, timeoutHit, lastByte, inHold;

    assign freeSpace  = CW'(DEPTH) - count_q;
    assign s_ready_o  = online_i & (freeSpace >= CW'(IN_BYTES));
    assign push       = s_valid_i & s_ready_o;
    assign pop        = (state_q == SEND) & ep_ready_i & online_i;
    assign timeoutHit = (timer_q == TW'(TIMEOUT));
    assign lastByte   = (pktCnt_q == pktLen_q - LW'(1));

`ifdef USB_CDC_TX_ZLP_EN
    assign inHold = (state_q == HOLD);
`else
    assign inHold = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                mem[wrPtr_q + AW'(i)] <= s_data_i[8*i +: 8];
            end
        end
    end

    // The idle timer also runs in HOLD so an empty FIFO can still time out into a ZLP.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        timer_d = timer_q;
        count_d = count_q + (push ? CW'(IN_BYTES) : '0) - (pop ? CW'(1) : '0);
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(IN_BYTES);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push) begin
            timer_d = '0;
        end else if (((count_q != '0) || inHold) && !timeoutHit) begin
            timer_d = timer_q + TW'(1);
        end
        if (!online_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            timer_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        pktLen_d = pktLen_q;
        pktCnt_d = pktCnt_q;
        data_d   = data_q;
        dval_d   = 1'b0;
        pktend_d = 1'b0;
        zlp_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q >= CW'(MAX_PKT)) || ((count_q != '0) && timeoutHit)) begin
                    state_d  = SEND;
                    pktLen_d = (count_q >= CW'(MAX_PKT)) ? LW'(MAX_PKT) : LW'(count_q);
                    pktCnt_d = '0;
                end
            end
            SEND: begin
                if (pop) begin
                    dval_d   = 1'b1;
                    data_d   = mem[rdPtr_q];
                    pktend_d = lastByte;
                    pktCnt_d = pktCnt_q + LW'(1);
                    if (lastByte) begin
                        state_d = IDLE;
`ifdef USB_CDC_TX_ZLP_EN
                        if ((pktLen_q == LW'(MAX_PKT)) && (count_d == '0)) begin
                            state_d = HOLD;
                        end
`endif
                    end
                end
            end
`ifdef USB_CDC_TX_ZLP_EN
            HOLD: begin
                if (push || (count_q != '0)) begin
                    state_d = IDLE;
                end else if (timeoutHit) begin
                    state_d = ZLP;
                end
            end
            ZLP: begin
                if (ep_ready_i) begin
                    zlp_d    = 1'b1;
                    pktend_d = 1'b1;
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        if (!online_i) begin
            state_d  = IDLE;
            pktCnt_d = '0;
            data_d   = '0;
            dval_d   = 1'b0;
            pktend_d = 1'b0;
            zlp_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            pktLen_q <= '0;
            pktCnt_q <= '0;
            dval_q   <= 1'b0;
            pktend_q <= 1'b0;
            zlp_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            pktLen_q <= pktLen_d;
            pktCnt_q <= pktCnt_d;
            dval_q   <= dval_d;
            pktend_q <= pktend_d;
            zlp_q    <= zlp_d;
            data_q   <= data_d;
        end
    end

    assign ep_dval_o   = dval_q;
    assign ep_data_o   = data_q;
    assign ep_pktend_o = pktend_q;
    assign ep_zlp_o    = zlp_q;
    assign fill_o      = count_q;

endmodule

// File: doc/usb_cdc_stream_tx.md
# usb_cdc_stream_tx

Parametrised device-to-host packetizer for the CDC data IN endpoint. It buffers a user byte stream arriving in beats of `IN_BYTES` bytes and serialises it into the endpoint-2 TX write port of `usb_fifo` as framed packets. A packet is closed on `MAX_PKT` bytes or on an idle timeout, with optional zero-length-packet (ZLP) termination. It sits between application logic and `usb_fifo` in the CDC top, in the `PHY_CLKOUT` domain.

## Interface
- `DEPTH`, 256: byte FIFO depth; power of two, ≥ 2·`MAX_PKT`.
- `MAX_PKT`, 64: maximum packet size in bytes (64 FS bulk, 512 HS bulk).
- `TIMEOUT`, 1024: idle cycles before a short packet is flushed; ≥ 1.
- `IN_BYTES`, 1: bytes per input beat; one of 1, 2 or 4.

Ports:
- `clk_i` in 1: clock (`PHY_CLKOUT`, 60 MHz).
- `rst_n_i` in 1: asynchronous active-low reset.
- `online_i` in 1: `online_o` from the device controller. Low flushes the block.
- `s_data_i` in 8·`IN_BYTES`: input beat; byte 0 is `[7:0]` and is sent first.
- `s_valid_i` in 1: input beat valid.
- `s_ready_o` out 1: beat accepted when `s_valid_i & s_ready_o`.
- `ep_ready_i` in 1: endpoint can take ≥ 2 more bytes.
- `ep_dval_o` out 1: byte strobe on `ep_data_o`.
- `ep_data_o` out 8: payload byte.
- `ep_pktend_o` out 1: last byte of a packet, or the ZLP marker.
- `ep_zlp_o` out 1: zero-length-packet request, one-cycle pulse.
- `fill_o` out clog2(`DEPTH`)+1: bytes currently buffered.

## Operation
- **FIFO**
  - `DEPTH`-byte circular buffer with read/write pointers that wrap at `DEPTH`.
  - `count` is updated with the net of push (`IN_BYTES`) and pop (1) in the same cycle.
- **Input acceptance**
  - `s_ready_o = online_i & (DEPTH − count ≥ IN_BYTES)`, computed from registered `count`.
  - Beats are never partially accepted.
- **Idle timer**
  - Clears on every accepted beat.
  - Otherwise increments while `count > 0`, saturating at `TIMEOUT`.
- **FSM states: IDLE, SEND, HOLD (post-full-packet), ZLP.**
  - IDLE → SEND when `count ≥ MAX_PKT`, or when `count > 0` and timer == `TIMEOUT`.
    - On entry, latch `pkt_len = min(count, MAX_PKT)` and clear `pkt_cnt`.
  - SEND: each cycle with `ep_ready_i=1`, pop one byte, register it onto `ep_data_o`, pulse `ep_dval_o`, increment `pkt_cnt`.
    - `ep_pktend_o=1` with the byte where `pkt_cnt == pkt_len−1`.
    - `ep_ready_i=0` stalls the packet with no byte lost.
  - After the last byte of a packet:
    - If `pkt_len == MAX_PKT` and `count == 0` after the pop → HOLD.
    - Otherwise → IDLE.
  - HOLD:
    - If `count ≥ MAX_PKT` or any new data arrives → IDLE (normal framing resumes).
    - If timer reaches `TIMEOUT` with `count == 0` → ZLP. The timer keeps counting in HOLD even though `count == 0`.
  - ZLP: waits for `ep_ready_i=1`, then pulses `ep_zlp_o=1` and `ep_pktend_o=1` with `ep_dval_o=0` for one cycle → IDLE.
- **`online_i` low** (any state, including mid-packet):
  - Next edge: pointers, `count`, timer and FSM are cleared to IDLE; all strobes go to 0.
  - The partial packet is discarded.
- **Reset:** all outputs are 0 and the FSM is in IDLE. Because `online_i` is low in reset, `s_ready_o=0` too.

## Timing
- All outputs except `s_ready_o` are registered. `s_ready_o` is decoded from registers only.
- Packet-start latency:
  - Cycle t: the accepted beat makes `count` reach `MAX_PKT`.
  - t+1: FSM enters SEND.
  - t+2: first `ep_dval_o`.
- Throughput: one byte per cycle while `ep_ready_i=1`. Back-to-back packets are separated by ≥ 1 idle cycle in IDLE.
- Timeout flush: first byte appears `TIMEOUT`+2 cycles after the last accepted beat.
- `fill_o` reflects `count` one cycle after a push or pop.

## Configuration
- Macro: `USB_CDC_TX_ZLP_EN`.
  - Defined: HOLD and ZLP states exist as described.
  - Undefined: after a full-size packet the FSM always returns to IDLE. `ep_zlp_o` is tied to 0.

## Test plan
Defaults apply (`DEPTH=256`, `MAX_PKT=64`, `TIMEOUT=100`, `IN_BYTES=1`) unless stated otherwise.

1. **Full packet:** push 0x00–0x3F back-to-back with `ep_ready_i=1`.
   - 64 `ep_dval_o` pulses in order; `ep_pktend_o` only with 0x3F.
   - With `USB_CDC_TX_ZLP_EN`: one `ep_zlp_o` pulse 102 cycles after the last push.
   - Without the macro: no ZLP.
2. **Short packet:** push 0xA1–0xA5, then idle.
   - Nothing is emitted for 100 cycles.
   - Then 5 bytes with `ep_pktend_o` on 0xA5; no ZLP.
3. **Backpressure:** hold `ep_ready_i=0` and offer 300 bytes.
   - `s_ready_o` drops after 256 accepted; `fill_o=256`.
   - Release: four 64-byte packets; data matches the push order across the pointer wrap.
4. **Wide input:** `IN_BYTES=4`, beats 0x44332211 then 0x88776655.
   - Output bytes in order: 11 22 33 44 55 66 77 88.
   - `s_ready_o` is low whenever free space < 4.
5. **Offline mid-packet:** drop `online_i` after 10 of 64 bytes are sent.
   - Strobes go to 0 next cycle; `fill_o=0`.
   - After `online_i` returns, pushing 3 bytes gives a fresh 3-byte packet.
6. **Reset:** assert `rst_n_i` asynchronously mid-SEND.
   - All outputs are 0 immediately.
   - After release, the FIFO is empty and no stale bytes are emitted.
